// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready stream bundle between pipeline stages
//
// Purpose: carries one payload beat with a valid/ready handshake.
// Ports (modports):
//    master : drives tvalid, tdata; samples tready
//    slave  : samples tvalid, tdata; drives tready
interface pipe_stage_skid_if #(
   parameter int WIDTH = 32
);
   logic             tvalid;
   logic [WIDTH-1:0] tdata;
   logic             tready;

   modport master (output tvalid, output tdata, input tready);
   modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - generic pipeline stage register with one-entry skid buffer
//
// Purpose: registers a WIDTH-bit beat between two pipeline stages. The skid
// entry absorbs the one beat that may arrive while downstream stalls, so
// in_if.tready depends on registered state only.
// Ports:
//    clk        in   rising-edge clock
//    rst        in   asynchronous active-high reset
//    flush      in   synchronous kill of stage contents (beats are dropped)
//    in_if      slave  upstream beat (tvalid/tdata in, tready out)
//    out_if     master downstream beat (tvalid/tdata out, tready in)
//    occupancy  out  beats held: 0, 1 or 2
module pipe_stage_skid #(
   parameter int               WIDTH       = 32,
   parameter bit               FLUSH_CLEAR = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   pipe_stage_skid_if.slave        in_if,
   pipe_stage_skid_if.master       out_if,
   output logic [1:0]              occupancy
);

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_ready;
   logic             out_valid;
   logic             accept;
   logic             release_beat;

   // State and payload registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= RESET_VAL;
         skid_q  <= RESET_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   assign accept       = in_if.tvalid & in_ready;
   assign release_beat = out_valid & out_if.tready;

   // Next state and payload. Flush overrides any handshake in the same cycle.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         if (FLUSH_CLEAR) begin
            main_d = '0;
            skid_d = '0;
         end
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_d  = in_if.tdata;
                  state_d = BUSY;
               end
            end
            BUSY: begin
               if (accept && release_beat) begin
                  main_d = in_if.tdata;
               end else if (accept) begin
                  // Downstream stalled: park the new beat, main keeps the oldest.
                  skid_d  = in_if.tdata;
                  state_d = FULL;
               end else if (release_beat) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (release_beat) begin
                  main_d  = skid_q;
                  state_d = BUSY;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   // Outputs come from registered state only: no path from out_if.tready or
   // in_if.tvalid to in_if.tready.
   always_comb begin
      in_ready  = (state_q != FULL);
      out_valid = (state_q != EMPTY);
      occupancy = state_q;
   end

   assign in_if.tready  = in_ready;
   assign out_if.tvalid = out_valid;
   assign out_if.tdata  = main_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - testbench for pipe_stage_skid
module tb_pipe_stage_skid;

   localparam logic [31:0] RV = 32'h0000_DEAD;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;
   logic [1:0]  occ_a, occ_b;

   int checks = 0;
   int errors = 0;

   pipe_stage_skid_if #(.WIDTH(32)) in_a ();
   pipe_stage_skid_if #(.WIDTH(32)) out_a ();
   pipe_stage_skid_if #(.WIDTH(32)) in_b ();
   pipe_stage_skid_if #(.WIDTH(32)) out_b ();

   assign in_a.tvalid  = in_valid;
   assign in_a.tdata   = in_data;
   assign out_a.tready = out_ready;
   assign in_b.tvalid  = in_valid;
   assign in_b.tdata   = in_data;
   assign out_b.tready = out_ready;

   // dut_a clears payload on flush, dut_b keeps it.
   pipe_stage_skid #(.WIDTH(32), .FLUSH_CLEAR(1'b1), .RESET_VAL(RV)) dut_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_if(in_a), .out_if(out_a), .occupancy(occ_a)
   );
   pipe_stage_skid #(.WIDTH(32), .FLUSH_CLEAR(1'b0), .RESET_VAL(RV)) dut_b (
      .clk(clk), .rst(rst), .flush(flush),
      .in_if(in_b), .out_if(out_b), .occupancy(occ_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [31:0] id;
      logic        ordy;
      logic        fl;
      logic        ev;
      logic        er;
      logic [1:0]  eo;
      logic [31:0] ed;
      logic [31:0] edk;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic iv, input logic [31:0] id, input logic ordy, input logic fl,
                      input logic ev, input logic er, input logic [1:0] eo,
                      input logic [31:0] ed, input logic [31:0] edk);
      vec_t v;
      v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
      v.ev = ev; v.er = er; v.eo = eo; v.ed = ed; v.edk = edk;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic ev, input logic er,
                            input logic [1:0] eo, input logic [31:0] ed);
      chk({tag, ".out_valid"}, {31'd0, out_a.tvalid}, {31'd0, ev});
      chk({tag, ".in_ready"},  {31'd0, in_a.tready},  {31'd0, er});
      chk({tag, ".occupancy"}, {30'd0, occ_a},        {30'd0, eo});
      chk({tag, ".out_data"},  out_a.tdata,           ed);
   endtask

   logic [31:0] q[$];
   logic        acc, rel, prev_hold;
   logic [31:0] prev_data;

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      for (int i = 0; i < 8; i++)
         add(1, 32'h10 + i, 1, 0, 1, 1, 1, 32'h10 + i, 32'h10 + i);
      add(0, 0,     1, 0, 0, 1, 0, 32'h17, 32'h17);
      add(1, 'hA0,  0, 0, 1, 1, 1, 'hA0,   'hA0);
      add(1, 'hA1,  0, 0, 1, 0, 2, 'hA0,   'hA0);
      add(1, 'hA2,  0, 0, 1, 0, 2, 'hA0,   'hA0);
      add(0, 0,     1, 0, 1, 1, 1, 'hA1,   'hA1);
      add(0, 0,     1, 0, 0, 1, 0, 'hA1,   'hA1);
      add(1, 'hC0,  0, 0, 1, 1, 1, 'hC0,   'hC0);
      add(0, 0,     0, 0, 1, 1, 1, 'hC0,   'hC0);
      add(1, 'hC1,  1, 0, 1, 1, 1, 'hC1,   'hC1);
      add(0, 0,     1, 0, 0, 1, 0, 'hC1,   'hC1);
      add(1, 'hB0,  0, 0, 1, 1, 1, 'hB0,   'hB0);
      add(1, 'hB1,  0, 0, 1, 0, 2, 'hB0,   'hB0);
      add(1, 'hB2,  1, 1, 0, 1, 0, 0,      'hB0);
      add(1, 'hD0,  1, 1, 0, 1, 0, 0,      'hB0);
      add(1, 'hD0,  1, 1, 0, 1, 0, 0,      'hB0);
      add(1, 'hD1,  0, 0, 1, 1, 1, 'hD1,   'hD1);
      add(1, 'hD2,  0, 0, 1, 0, 2, 'hD1,   'hD1);
      add(0, 0,     1, 0, 1, 1, 1, 'hD2,   'hD2);
      add(0, 0,     1, 1, 0, 1, 0, 0,      'hD2);
      add(0, 0,     0, 0, 0, 1, 0, 0,      'hD2);

      // Reset state
      #12;
      chk_state("reset", 0, 1, 0, RV);
      chk("reset.b_out_data", out_b.tdata, RV);
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors
      foreach (vecs[k]) begin
         in_valid = vecs[k].iv; in_data = vecs[k].id;
         out_ready = vecs[k].ordy; flush = vecs[k].fl;
         @(posedge clk); #1;
         chk_state($sformatf("vec%0d", k), vecs[k].ev, vecs[k].er, vecs[k].eo, vecs[k].ed);
         chk($sformatf("vec%0d.b_out_data", k), out_b.tdata, vecs[k].edk);
         chk($sformatf("vec%0d.b_out_valid", k), {31'd0, out_b.tvalid}, {31'd0, vecs[k].ev});
      end

      // Random valid/ready against a queue scoreboard
      flush = 1'b0;
      prev_hold = 1'b0;
      prev_data = '0;
      for (int c = 0; c < 10000; c++) begin
         chk("rnd.out_valid", {31'd0, out_a.tvalid}, {31'd0, q.size() != 0});
         chk("rnd.occupancy", {30'd0, occ_a}, q.size());
         chk("rnd.in_ready", {31'd0, in_a.tready}, {31'd0, q.size() < 2});
         if (q.size() != 0) chk("rnd.out_data", out_a.tdata, q[0]);
         if (prev_hold) chk("rnd.hold_data", out_a.tdata, prev_data);
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = $urandom;
         out_ready = 1'($urandom_range(0, 1));
         acc = in_valid & in_a.tready;
         rel = out_a.tvalid & out_ready;
         prev_hold = out_a.tvalid & ~out_ready;
         prev_data = out_a.tdata;
         @(posedge clk); #1;
         if (rel && q.size() != 0) void'(q.pop_front());
         if (acc) q.push_back(in_data);
      end

      // Drain, then async reset while BUSY
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b1; in_data = 32'hE0; out_ready = 1'b0;
      @(posedge clk); #1;
      chk_state("pre_rst", 1, 1, 1, 32'hE0);
      #2 rst = 1'b1;
      #1;
      chk_state("async_rst", 0, 1, 0, RV);
      #1 rst = 1'b0;
      in_data = 32'hE1; out_ready = 1'b1;
      @(posedge clk); #1;
      chk_state("post_rst", 1, 1, 1, 32'hE1);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk_state("post_rst_drain", 0, 1, 0, 32'hE1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
